// File: rtl/sdw_pkg.sv
// Shared types and defaults for the single-digit stopwatch.
package sdw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } sdw_state_t;

  localparam int DEFAULT_MODULUS = 10;
  localparam int DEFAULT_WIDTH   = 4;

endpackage

// File: rtl/mod_counter.sv
// Mod-N up-counter with enable. at_max flags the last value before the wrap.
module mod_counter
  import sdw_pkg::*;
#(
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next count: wrap to zero after MAX_VAL so the value never leaves 0..MODULUS-1.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (q_q == MAX_VAL) begin
        q_d = {WIDTH{1'b0}};
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == MAX_VAL);

endmodule

// File: rtl/single_digit_watch.sv
// One stopwatch digit: run/pause/clear FSM around a mod-N counter plus carry out.
// Define SDW_REG_CARRY_EN to register cout (high in the cycle after the wrap).
module single_digit_watch
  import sdw_pkg::*;
#(
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  output logic [WIDTH-1:0] number,
  output logic             cout
);

  sdw_state_t state_d;
  sdw_state_t state_q;
  logic       run_s;
  logic       at_max_s;

  // start_resume outranks stop; stop only matters while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_resume) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (start_resume) begin
          state_d = RUN;
        end else if (stop) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (start_resume) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Enable comes from the registered state, so a stop still lets its own edge count.
  assign run_s = (state_q == RUN);

  mod_counter #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (run_s),
    .q      (number),
    .at_max (at_max_s)
  );

`ifdef SDW_REG_CARRY_EN
  logic cout_d;
  logic cout_q;

  assign cout_d = run_s && at_max_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
`else
  assign cout = run_s && at_max_s;
`endif

endmodule

// File: tb/tb_single_digit_watch.sv
// Directed table-driven bench for single_digit_watch (default and MODULUS=6 instances).
module tb_single_digit_watch;

  typedef struct {
    logic       r;
    logic       s;
    logic       p;
    logic [3:0] n;
    logic       c;
    logic       cr;
  } vec_t;

`ifdef SDW_REG_CARRY_EN
  localparam bit REG_CARRY = 1'b1;
`else
  localparam bit REG_CARRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_resume = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] number;
  logic       cout;

  logic       reset6 = 1'b1;
  logic       start6 = 1'b0;
  logic       stop6 = 1'b0;
  logic [2:0] number6;
  logic       cout6;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  single_digit_watch dut (
    .clk          (clk),
    .reset        (reset),
    .start_resume (start_resume),
    .stop         (stop),
    .number       (number),
    .cout         (cout)
  );

  single_digit_watch #(.MODULUS(6), .WIDTH(3)) dut6 (
    .clk          (clk),
    .reset        (reset6),
    .start_resume (start6),
    .stop         (stop6),
    .number       (number6),
    .cout         (cout6)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic s, input logic p,
                              input int n, input logic c, input logic cr);
    vecs.push_back('{r, s, p, 4'(n), c, cr});
  endfunction

  initial begin
    // reset held 5 edges with start_resume high
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0);
    // start at edge k, count 1..9, wrap to 0, then 1
    add(0, 1, 0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) add(0, 0, 0, n, 0, 0);
    add(0, 0, 0, 9, 1, 0);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0);
    for (int n = 2; n <= 4; n++) add(0, 0, 0, n, 0, 0);
    // stop at 4: its own edge still counts, then hold 5
    add(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 5, 0, 0);
    add(0, 1, 0, 5, 0, 0);
    add(0, 0, 0, 6, 0, 0);
    add(0, 0, 0, 7, 0, 0);
    // pause landing on 9: no carry while paused, carry on resume
    add(0, 0, 0, 8, 0, 0);
    add(0, 0, 1, 9, 0, 0);
    add(0, 0, 0, 9, 0, 0);
    add(0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 9, 1, 0);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0);
    // start and stop together keep running
    add(0, 1, 1, 2, 0, 0);
    add(0, 1, 1, 3, 0, 0);
    for (int n = 4; n <= 7; n++) add(0, 0, 0, n, 0, 0);
    // mid-count reset, then idle until start_resume
    add(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      reset        = v.r;
      start_resume = v.s;
      stop         = v.p;
      @(posedge clk);
      #1;
      check($sformatf("number[%0d]", i), int'(number), int'(v.n));
      check($sformatf("cout[%0d]", i), int'(cout), int'(REG_CARRY ? v.cr : v.c));
    end

    // MODULUS=6 instance: reset, start, then run two full wraps
    begin
      int exp_n;
      int prev_n;
      int exp_c;
      reset6 = 1'b1;
      @(posedge clk);
      #1;
      check("m6_reset_number", int'(number6), 0);
      check("m6_reset_cout", int'(cout6), 0);
      reset6 = 1'b0;
      start6 = 1'b1;
      @(posedge clk);
      #1;
      check("m6_start_number", int'(number6), 0);
      start6 = 1'b0;
      exp_n = 0;
      for (int i = 0; i < 14; i++) begin
        prev_n = exp_n;
        exp_n  = (prev_n == 5) ? 0 : prev_n + 1;
        exp_c  = REG_CARRY ? int'(prev_n == 5) : int'(exp_n == 5);
        @(posedge clk);
        #1;
        check($sformatf("m6_number[%0d]", i), int'(number6), exp_n);
        check($sformatf("m6_cout[%0d]", i), int'(cout6), exp_c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
